// File: rtl/pattern_recognition_pkg.sv
// Shared types and helpers for the pattern-recognition pixel pipeline.
package pattern_recognition_pkg;

    typedef enum logic [1:0] {RUN, MUL, UPD} thresh_state_t;

    localparam int unsigned RECIP_W = 33;
    localparam int unsigned FLAG_W  = 3;

    // round(2^32 / n), used to turn a frame sum into a mean without a divider
    function automatic logic [RECIP_W-1:0] recip32(input longint unsigned n);
        longint unsigned r;
        r = ((64'd1 << 32) + (n >> 1)) / n;
        return r[RECIP_W-1:0];
    endfunction

endpackage

// File: rtl/stream_reg_stage.sv
// Single-entry valid/ready register slice; accepts new data in the same cycle it drains.
module stream_reg_stage #(
    parameter int unsigned DW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/adaptive_threshold_stage.sv
// Streaming binarizer: static or previous-frame-mean-relative threshold, raster position flags.
module adaptive_threshold_stage
    import pattern_recognition_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned W          = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         x_valid,
    output logic         x_ready,
    input  logic [W-1:0] x_data,
    output logic         y_valid,
    input  logic         y_ready,
    output logic [W-1:0] y_data,
    output logic         y_sof,
    output logic         y_eol,
    output logic         y_eof,
    input  logic         thresh_mode,
    input  logic [W-1:0] thresh_static,
    input  logic [W-1:0] thresh_offset,
    input  logic         invert,
    output logic [W-1:0] frame_mean,
    output logic         frame_done
);

    localparam int unsigned N      = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned SUM_W  = W + $clog2(N);
    localparam int unsigned PROD_W = SUM_W + RECIP_W;
    localparam int unsigned COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [RECIP_W-1:0] RECIP      = recip32(64'(N));
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [PROD_W:0]    ROUND_HALF = {{(PROD_W - 31){1'b0}}, 1'b1, 31'd0};

    thresh_state_t     state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [SUM_W-1:0]  acc_q, acc_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [W-1:0]      mean_q, mean_d;
    logic              done_q, done_d;
    logic              have_mean_q, have_mean_d;
    logic              cfg_mode_q, cfg_mode_d;
    logic [W-1:0]      cfg_static_q, cfg_static_d;
    logic [W-1:0]      cfg_offset_q, cfg_offset_d;
    logic              cfg_invert_q, cfg_invert_d;

    logic              s_in_valid, s_in_ready, accept;
    logic              first_px, last_col, last_px;
    logic              mode_eff, inv_eff;
    logic [W-1:0]      static_eff, offset_eff;
    logic signed [W+1:0] t_sum;
    logic [W-1:0]      thr, pix_out;
    logic [PROD_W:0]   prod_rnd;
    logic [W+FLAG_W-1:0] out_word;

    assign s_in_valid = x_valid && (state_q == RUN);
    assign x_ready    = (state_q == RUN) && s_in_ready;
    assign accept     = x_valid && x_ready;

    assign first_px = (col_q == '0) && (row_q == '0);
    assign last_col = (col_q == COL_LAST);
    assign last_px  = last_col && (row_q == ROW_LAST);

    // Pixel 0 must see the live config, since the latched copy only updates on its accept
    assign mode_eff   = first_px ? thresh_mode   : cfg_mode_q;
    assign static_eff = first_px ? thresh_static : cfg_static_q;
    assign offset_eff = first_px ? thresh_offset : cfg_offset_q;
    assign inv_eff    = first_px ? invert        : cfg_invert_q;

    always_comb begin
        t_sum = $signed({2'b00, mean_q}) + $signed({{2{offset_eff[W-1]}}, offset_eff});
        if (!mode_eff || !have_mean_q) begin
            thr = static_eff;
        end else if (t_sum[W+1]) begin
            thr = '0;
        end else if (t_sum[W]) begin
            thr = '1;
        end else begin
            thr = t_sum[W-1:0];
        end
        pix_out = ((x_data > thr) ^ inv_eff) ? '1 : '0;
    end

    assign prod_rnd = {1'b0, prod_q} + ROUND_HALF;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        acc_d        = acc_q;
        sum_d        = sum_q;
        prod_d       = prod_q;
        mean_d       = mean_q;
        done_d       = 1'b0;
        have_mean_d  = have_mean_q;
        cfg_mode_d   = cfg_mode_q;
        cfg_static_d = cfg_static_q;
        cfg_offset_d = cfg_offset_q;
        cfg_invert_d = cfg_invert_q;

        if (accept && first_px) begin
            cfg_mode_d   = thresh_mode;
            cfg_static_d = thresh_static;
            cfg_offset_d = thresh_offset;
            cfg_invert_d = invert;
        end

        case (state_q)
            RUN: begin
                if (accept) begin
                    acc_d = acc_q + SUM_W'(x_data);
                    if (last_col) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (last_px) begin
                        sum_d   = acc_q + SUM_W'(x_data);
                        acc_d   = '0;
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                prod_d  = PROD_W'(sum_q) * PROD_W'(RECIP);
                state_d = UPD;
            end
            UPD: begin
                mean_d      = prod_rnd[32 +: W];
                have_mean_d = 1'b1;
                done_d      = 1'b1;
                state_d     = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            col_q        <= '0;
            row_q        <= '0;
            acc_q        <= '0;
            sum_q        <= '0;
            prod_q       <= '0;
            mean_q       <= '0;
            done_q       <= 1'b0;
            have_mean_q  <= 1'b0;
            cfg_mode_q   <= 1'b0;
            cfg_static_q <= '0;
            cfg_offset_q <= '0;
            cfg_invert_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            acc_q        <= acc_d;
            sum_q        <= sum_d;
            prod_q       <= prod_d;
            mean_q       <= mean_d;
            done_q       <= done_d;
            have_mean_q  <= have_mean_d;
            cfg_mode_q   <= cfg_mode_d;
            cfg_static_q <= cfg_static_d;
            cfg_offset_q <= cfg_offset_d;
            cfg_invert_q <= cfg_invert_d;
        end
    end

    stream_reg_stage #(
        .DW(W + FLAG_W)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s_in_valid),
        .in_ready (s_in_ready),
        .in_data  ({first_px, last_col, last_px, pix_out}),
        .out_valid(y_valid),
        .out_ready(y_ready),
        .out_data (out_word)
    );

    assign y_sof      = out_word[W+2];
    assign y_eol      = out_word[W+1];
    assign y_eof      = out_word[W];
    assign y_data     = out_word[W-1:0];
    assign frame_mean = mean_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_adaptive_threshold_stage.sv
// Randomized and directed bench for adaptive_threshold_stage against a frame-level reference model.
module tb_adaptive_threshold_stage;

    localparam int unsigned IW = 4;
    localparam int unsigned IH = 2;
    localparam int unsigned NPIX = IW * IH;

    logic       clk = 0;
    logic       rst = 1;
    logic       x_valid = 0;
    logic       x_ready;
    logic [7:0] x_data = '0;
    logic       y_valid;
    logic       y_ready = 1;
    logic [7:0] y_data;
    logic       y_sof, y_eol, y_eof;
    logic       thresh_mode = 0;
    logic [7:0] thresh_static = 8'h80;
    logic [7:0] thresh_offset = 8'h00;
    logic       invert = 0;
    logic [7:0] frame_mean;
    logic       frame_done;

    always #5 clk = ~clk;

    adaptive_threshold_stage #(
        .IMG_WIDTH (IW),
        .IMG_HEIGHT(IH),
        .W         (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .x_data       (x_data),
        .y_valid      (y_valid),
        .y_ready      (y_ready),
        .y_data       (y_data),
        .y_sof        (y_sof),
        .y_eol        (y_eol),
        .y_eof        (y_eof),
        .thresh_mode  (thresh_mode),
        .thresh_static(thresh_static),
        .thresh_offset(thresh_offset),
        .invert       (invert),
        .frame_mean   (frame_mean),
        .frame_done   (frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        bit sof, eol, eof;
    } out_t;

    longint recip = $rtoi((2.0 ** 32) / NPIX + 0.5);

    out_t q[$];
    int   idx = 0;
    int   run_sum = 0;
    int   pend_sum = 0;
    int   ctr = 0;
    int   m_mean = 0;
    bit   m_have = 0;
    int   n_out = 0;
    bit   c_mode, c_inv;
    int   c_static, c_off;

    always @(negedge clk) begin
        bit   exp_ready;
        int   t;
        bit   hit;
        out_t o;
        if (ctr > 0) begin
            ctr--;
            if (ctr == 1) begin
                m_mean = int'(((longint'(pend_sum) * recip) + (64'd1 << 31)) >> 32) & 255;
                m_have = 1;
            end
        end
        exp_ready = (ctr < 2) && (q.size() == 0 || y_ready);
        check_eq("x_ready", x_ready, exp_ready);
        check_eq("frame_done", frame_done, ctr == 1);
        check_eq("frame_mean", frame_mean, m_mean);
        check_eq("y_valid", y_valid, q.size() != 0);
        if (q.size() != 0) begin
            check_eq("y_data", y_data, q[0].d);
            check_eq("y_flags", {y_sof, y_eol, y_eof}, {q[0].sof, q[0].eol, q[0].eof});
        end
        if (rst) begin
            q.delete();
            idx = 0; run_sum = 0; ctr = 0; m_mean = 0; m_have = 0;
        end else begin
            if (y_valid && y_ready && q.size() != 0) begin
                void'(q.pop_front());
                n_out++;
            end
            if (x_valid && exp_ready) begin
                if (idx == 0) begin
                    c_mode = thresh_mode; c_inv = invert;
                    c_static = thresh_static; c_off = int'($signed(thresh_offset));
                end
                if (!c_mode || !m_have) t = c_static;
                else begin
                    t = m_mean + c_off;
                    if (t < 0) t = 0;
                    if (t > 255) t = 255;
                end
                hit = (int'(x_data) > t) ^ c_inv;
                o.d = hit ? 8'hFF : 8'h00;
                o.sof = (idx == 0);
                o.eol = (idx % IW == IW - 1);
                o.eof = (idx == NPIX - 1);
                q.push_back(o);
                run_sum += int'(x_data);
                idx++;
                if (idx == NPIX) begin
                    idx = 0; pend_sum = run_sum; run_sum = 0; ctr = 4;
                end
            end
        end
    end

    bit rand_yr = 0;
    bit rand_cfg = 0;
    int hold_cnt = 0;

    task automatic step();
        @(posedge clk); #1;
        if (hold_cnt > 0) begin
            y_ready = 0;
            hold_cnt--;
        end else if (rand_yr) y_ready = ($urandom_range(0, 3) != 0);
        else y_ready = 1;
    endtask

    task automatic send_pixel(input logic [7:0] px);
        bit acc = 0;
        if (rand_cfg) begin
            thresh_mode = 1'($urandom); invert = 1'($urandom);
            thresh_static = 8'($urandom); thresh_offset = 8'($urandom);
        end
        x_valid = 1; x_data = px;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = x_ready;
            step();
        end
        x_valid = 0;
        if (!acc) check_eq("accept_timeout", 0, 1);
    endtask

    task automatic wait_done(output int lat);
        bit seen = 0;
        lat = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = frame_done;
            if (seen) lat = i + 1;
            step();
        end
        check_eq("frame_done_seen", seen, 1);
    endtask

    task automatic idle(input int n);
        x_valid = 0;
        repeat (n) step();
    endtask

    task automatic send_const_frame(input logic [7:0] px);
        for (int i = 0; i < NPIX; i++) send_pixel(px);
    endtask

    initial begin
        logic [7:0] f2 [8] = '{8'h41, 8'h40, 8'h3F, 8'hFF, 8'h00, 8'h41, 8'h40, 8'h80};
        int lat;
        int out0;

        repeat (2) step();
        check_eq("rst_y_valid", y_valid, 0);
        check_eq("rst_y_data", y_data, 0);
        check_eq("rst_flags", {y_sof, y_eol, y_eof}, 0);
        check_eq("rst_mean", frame_mean, 0);
        check_eq("rst_done", frame_done, 0);
        rst = 0;
        step();

        // Frame 1: static 0x80, flat 0x40
        thresh_mode = 0; thresh_static = 8'h80;
        send_const_frame(8'h40);
        wait_done(lat);
        check_eq("f1_done_latency", lat, 3);
        check_eq("f1_mean", frame_mean, 8'h40);

        // Frame 2: adaptive, offset 0, with a 3-cycle backpressure mid-line
        thresh_mode = 1; thresh_offset = 8'h00;
        out0 = n_out;
        for (int i = 0; i < 8; i++) begin
            send_pixel(f2[i]);
            if (i == 1) hold_cnt = 3;
        end
        wait_done(lat);
        idle(2);
        check_eq("f2_out_count", n_out - out0, 8);
        check_eq("f2_mean", frame_mean, 8'h58);

        // Clamp high
        thresh_mode = 0;
        send_const_frame(8'hF0);
        thresh_mode = 1; thresh_offset = 8'h20; invert = 0;
        send_pixel(8'hFF);
        check_eq("clamp_hi", y_data, 8'h00);
        for (int i = 1; i < NPIX; i++) send_pixel(8'hF0);
        invert = 1;
        send_pixel(8'hFF);
        check_eq("clamp_hi_inv", y_data, 8'hFF);
        for (int i = 1; i < NPIX; i++) send_pixel(8'hF0);

        // Clamp low
        invert = 0; thresh_mode = 0;
        send_const_frame(8'h10);
        thresh_mode = 1; thresh_offset = 8'hE0;
        send_pixel(8'h01);
        check_eq("clamp_lo", y_data, 8'hFF);
        for (int i = 1; i < NPIX; i++) send_pixel(8'h00);

        // Mid-frame reset with an output still held
        thresh_mode = 1; thresh_static = 8'h30; thresh_offset = 8'h00;
        send_pixel(8'h10);
        send_pixel(8'h20);
        send_pixel(8'h90);
        hold_cnt = 2;
        rst = 1;
        step();
        rst = 0;
        check_eq("mid_rst_y_valid", y_valid, 0);
        check_eq("mid_rst_mean", frame_mean, 0);
        send_pixel(8'h31);
        check_eq("mid_rst_sof", y_sof, 1);
        check_eq("mid_rst_static", y_data, 8'hFF);
        for (int i = 1; i < NPIX; i++) send_pixel(8'($urandom));

        // Randomized frames: random config per pixel, random gaps and backpressure
        rand_yr = 1; rand_cfg = 1;
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < NPIX; i++) begin
                send_pixel(8'($urandom));
                if ($urandom_range(0, 9) < 3) idle(1);
            end
        end
        rand_yr = 0; rand_cfg = 0;
        idle(10);
        check_eq("drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
